qam_upsample_fir: RTL and testbench

Parametrised successor to the 64QAM upsampling stage. It maps each input symbol to signed I/Q PAM levels using per-axis Gray decoding, and zero-stuffs by a runtime-programmable factor L. It then filters each rail with a runtime-writable NTAPS FIR and emits saturated signed I/Q samples every clock. It sits between the bit-to-symbol framer and the DAC/SPI output stage.

---
 rtl/qam_upsample_fir.sv | 159 +++++++++++++++
 tb/tb_qam_upsample_fir.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/qam_upsample_fir.sv
// qam_upsample_fir: Gray-mapped QAM symbol upsampler with
// per-rail programmable FIR, saturating I/Q outputs.
module qam_upsample_fir #(
  parameter int SYM_BITS = 6,
  parameter int NTAPS    = 8,
  parameter int COEF_W   = 8,
  parameter int RATE_W   = 4,
  parameter int SHIFT    = 0,
  parameter int OUT_W    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SYM_BITS-1:0]      sym_in,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  input  logic [RATE_W-1:0]        rate,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  output logic [OUT_W-1:0]         I_out,
  output logic [OUT_W-1:0]         Q_out,
  output logic                     out_valid,
  output logic                     ovf,
  output logic                     underrun
);

  localparam int M     = SYM_BITS / 2;
  localparam int AW    = $clog2(NTAPS);
  localparam int ACC_W = M + 1 + COEF_W + AW;
  localparam int SW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic signed [SW-1:0] MAXV =
    SW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [SW-1:0] MINV =
    SW'(-(2 ** (OUT_W - 1)));

  localparam logic [0:0] WAIT_FIRST = 1'b0;
  localparam logic [0:0] RUN        = 1'b1;

  // Gray code to binary index, then to odd PAM level.
  function automatic logic signed [M:0] lvl(
    input logic [M-1:0] g
  );
    logic [M-1:0] b;
    logic [M+1:0] t;
    b[M-1] = g[M-1];
    for (int i = M - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    t = {1'b0, b, 1'b0} - (M+2)'((1 << M) - 1);
    return t[M:0];
  endfunction

  // A programmed rate of zero means no upsampling.
  function automatic logic [RATE_W-1:0] leff(
    input logic [RATE_W-1:0] r
  );
    return (r == '0) ? RATE_W'(1) : r;
  endfunction

  // Clip to the output range; MSB flags a clip.
  function automatic logic [OUT_W:0] sat(
    input logic signed [SW-1:0] v
  );
    if (v > MAXV)
      return {1'b1, MAXV[OUT_W-1:0]};
    else if (v < MINV)
      return {1'b1, MINV[OUT_W-1:0]};
    else
      return {1'b0, v[OUT_W-1:0]};
  endfunction

  logic [RATE_W-1:0] phase_q, phase_d;
  logic [RATE_W-1:0] l_q, l_d;
  logic [0:0]        state_q, state_d;
  logic signed [M:0] dli_q [NTAPS];
  logic signed [M:0] dlq_q [NTAPS];
  logic signed [COEF_W-1:0] coef_q [NTAPS];
  logic [OUT_W-1:0]  i_q, q_q;
  logic              vld_q, ovf_q, udr_q, udr_d;

  logic              wrap, xfer;
  logic signed [M:0] xi, xq;
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [SW-1:0] sh_i, sh_q;
  logic [OUT_W-1:0]  si, sq;
  logic              ci, cq;

  assign sym_ready = (phase_q == '0);
  assign I_out     = i_q;
  assign Q_out     = q_q;
  assign out_valid = vld_q;
  assign ovf       = ovf_q;
  assign underrun  = udr_q;

  // Phase counter, rate latch, handshake and sample injection.
  always_comb begin
    wrap    = (phase_q == l_q - RATE_W'(1));
    phase_d = wrap ? '0 : phase_q + RATE_W'(1);
    l_d     = wrap ? leff(rate) : l_q;
    xfer    = sym_valid && sym_ready;
    xi      = xfer ? lvl(sym_in[SYM_BITS-1:M]) : '0;
    xq      = xfer ? lvl(sym_in[M-1:0]) : '0;
    state_d = xfer ? RUN : state_q;
    udr_d   = udr_q | (sym_ready & ~sym_valid &
                       (state_q == RUN));
  end

  // FIR sums over the delay lines, shift and saturate.
  always_comb begin
    acc_i = '0;
    acc_q = '0;
    for (int k = 0; k < NTAPS; k++) begin
      acc_i += ACC_W'(dli_q[k]) * ACC_W'(coef_q[k]);
      acc_q += ACC_W'(dlq_q[k]) * ACC_W'(coef_q[k]);
    end
    sh_i = SW'(acc_i) >>> SHIFT;
    sh_q = SW'(acc_q) >>> SHIFT;
    {ci, si} = sat(sh_i);
    {cq, sq} = sat(sh_q);
  end

  // State, delay lines, coefficients and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= '0;
      l_q     <= leff(rate);
      state_q <= WAIT_FIRST;
      for (int k = 0; k < NTAPS; k++) begin
        dli_q[k]  <= '0;
        dlq_q[k]  <= '0;
        coef_q[k] <= (k == 0) ? COEF_W'(1) : '0;
      end
      i_q   <= '0;
      q_q   <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      l_q      <= l_d;
      state_q  <= state_d;
      dli_q[0] <= xi;
      dlq_q[0] <= xq;
      for (int k = 1; k < NTAPS; k++) begin
        dli_q[k] <= dli_q[k-1];
        dlq_q[k] <= dlq_q[k-1];
      end
      if (coef_we &&
          ({1'b0, coef_addr} < (AW+1)'(NTAPS)))
        coef_q[coef_addr] <= coef_data;
      i_q   <= si;
      q_q   <= sq;
      vld_q <= (state_q == RUN);
      ovf_q <= ovf_q | ci | cq;
      udr_q <= udr_d;
    end
  end

endmodule

// File: tb/tb_qam_upsample_fir.sv
// tb_qam_upsample_fir: directed checks of mapping, upsampling,
// FIR, saturation, handshake, underrun, rate change and reset.
module tb_qam_upsample_fir;

  logic              clk = 1'b0;
  logic              rst;
  logic [5:0]        sym_in;
  logic              sym_valid;
  logic              sym_ready;
  logic [3:0]        rate;
  logic              coef_we;
  logic [2:0]        coef_addr;
  logic [7:0]        coef_data;
  logic signed [9:0] I_out;
  logic signed [9:0] Q_out;
  logic              out_valid;
  logic              ovf;
  logic              underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qam_upsample_fir dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .rate      (rate),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .I_out     (I_out),
    .Q_out     (Q_out),
    .out_valid (out_valid),
    .ovf       (ovf),
    .underrun  (underrun)
  );

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst       = 1'b0;
    rate      = r;
    sym_valid = 1'b0;
    coef_we   = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic wr_all(input logic [7:0] c);
    for (int k = 0; k < 8; k++) begin
      coef_we   = 1'b1;
      coef_addr = 3'(k);
      coef_data = c;
      step();
    end
    coef_we = 1'b0;
  endtask

  int map_i[4] = '{-7, 0, 0, 0};
  int map_q[4] = '{3, 0, 0, 0};
  int rc_rdy[9] = '{1, 0, 0, 0, 1, 0, 1, 0, 1};
  int xh[17];
  int ex;
  logic rdy_exp;

  initial begin
    rst       = 1'b0;
    sym_in    = '0;
    sym_valid = 1'b0;
    rate      = 4'd4;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_I", I_out, 0);
      chk("rst_Q", Q_out, 0);
      chk("rst_vld", out_valid, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_udr", underrun, 0);
    end
    rst = 1'b1;
    chk("rst_rdy", sym_ready, 1);

    sym_in    = 6'b000_111;
    sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    chk("map_lat", I_out, 0);
    chk("map_vld0", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("map_I", I_out, map_i[i]);
      chk("map_Q", Q_out, map_q[i]);
      if (i == 0) chk("map_vld1", out_valid, 1);
    end

    do_reset(4'd1);
    wr_all(8'd1);
    sym_in    = 6'b100_100;
    sym_valid = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      step();
      ex = (n - 1) * 7;
      if (ex > 56) ex = 56;
      chk("acc_I", I_out, ex);
    end
    chk("acc_ovf", ovf, 0);

    do_reset(4'd1);
    wr_all(8'd127);
    sym_in    = 6'b100_100;
    sym_valid = 1'b1;
    repeat (10) step();
    chk("sat_pos_I", I_out, 511);
    chk("sat_ovf", ovf, 1);
    sym_in = 6'b000_000;
    repeat (10) step();
    chk("sat_neg_I", I_out, -512);
    chk("sat_neg_Q", Q_out, -512);

    rst       = 1'b0;
    rate      = 4'd4;
    sym_valid = 1'b0;
    step();
    chk("mr_I", I_out, 0);
    chk("mr_Q", Q_out, 0);
    chk("mr_vld", out_valid, 0);
    chk("mr_ovf", ovf, 0);
    chk("mr_udr", underrun, 0);
    rst       = 1'b1;
    sym_in    = 6'b000_111;
    sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
    step();
    chk("mr_pass_I", I_out, -7);
    chk("mr_pass_Q", Q_out, 3);
    step();
    chk("mr_tap1_I", I_out, 0);
    chk("mr_tap1_ovf", ovf, 0);

    do_reset(4'd4);
    sym_in = 6'b100_000;
    xh[0]  = 0;
    for (int j = 1; j <= 16; j++) begin
      sym_valid = !(j >= 9 && j <= 12);
      rdy_exp   = ((j - 1) % 4 == 0);
      chk("hs_rdy", sym_ready, int'(rdy_exp));
      xh[j] = (rdy_exp && sym_valid) ? 7 : 0;
      step();
      if (j >= 2) chk("hs_I", I_out, xh[j-1]);
      if (j == 2) chk("hs_Q", Q_out, -7);
      if (j == 8) chk("hs_udr0", underrun, 0);
      if (j == 9) chk("hs_udr1", underrun, 1);
    end
    chk("hs_udr_sticky", underrun, 1);

    do_reset(4'd4);
    sym_in    = 6'b100_100;
    sym_valid = 1'b1;
    for (int j = 0; j < 9; j++) begin
      chk("rc_rdy", sym_ready, rc_rdy[j]);
      step();
      if (j == 0) rate = 4'd2;
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
